color_mem_arbiter: RTL and testbench

COLOR_MEM_ARBITER -- requirements
Module: color_mem_arbiter

---
 rtl/color_mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_color_mem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_mem_arbiter.sv
// color_mem_arbiter: shares one nibble-wide colour SRAM between a host port
// and a background fill engine, and owns the 7-bit colour bank register.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   host_req/we/addr/   host access request (held until host_ack), direction,
//   host_wdata          10-bit colour address and write nibble
//   host_rdata/ack      read nibble (held until next read ack), 1-cycle ack
//   fill_start/value    1-cycle fill trigger and the nibble to fill with
//   fill_busy/done      fill in progress, 1-cycle pulse after the last write
//   bank                bank register bits [5:0]
//   mem_addr/wdata      SRAM address {bank, addr} and write nibble
//   mem_rdata           SRAM byte, [7:4] upper half, [3:0] lower half
//   mem_drive           SRAM data pin drive enable
//   _ce_mem/_we_mem     SRAM chip / write enable, active low
//   _lb/_ub             lower / upper half select, active low
//
// Build option: define COLOR_FILL_EN to include the fill engine. Without it
// fill_busy/fill_done are tied low and fill_start/fill_value are ignored.

module color_mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [9:0]  host_addr,
    input  logic [3:0]  host_wdata,
    output logic [3:0]  host_rdata,
    output logic        host_ack,
    input  logic        fill_start,
    input  logic [3:0]  fill_value,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [5:0]  bank,
    output logic [15:0] mem_addr,
    output logic [3:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_drive,
    output logic        _ce_mem,
    output logic        _we_mem,
    output logic        _lb,
    output logic        _ub
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        FINISH
    } state_t;

    localparam logic [9:0] BANK_LO_ADDR = 10'h3FE;
    localparam logic [9:0] BANK_HI_ADDR = 10'h3FF;
    localparam logic [9:0] LAST_PTR     = 10'h3FF;

    state_t     state;

    // [5:0] bank, [6] half select (0 = lower, 1 = upper)
    logic [6:0] bank_reg;

    // Attributes of the access in flight, captured when it is granted
    logic       acc_host;
    logic       acc_we;
    logic       acc_half;
    logic [9:0] acc_addr;
    logic [3:0] acc_wdata;

`ifdef COLOR_FILL_EN
    logic [3:0] fill_nib;
    logic [5:0] fill_bank;
    logic       fill_half;
    logic [9:0] fill_ptr;
`else
    logic unused_fill;

    assign unused_fill = ^{fill_start, fill_value};
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
`endif

    assign bank = bank_reg[5:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bank_reg   <= 7'd0;
            acc_host   <= 1'b0;
            acc_we     <= 1'b0;
            acc_half   <= 1'b0;
            acc_addr   <= 10'd0;
            acc_wdata  <= 4'd0;
            host_ack   <= 1'b0;
            host_rdata <= 4'd0;
            mem_addr   <= 16'd0;
            mem_wdata  <= 4'd0;
            mem_drive  <= 1'b0;
            _ce_mem    <= 1'b1;
            _we_mem    <= 1'b1;
            _lb        <= 1'b1;
            _ub        <= 1'b1;
`ifdef COLOR_FILL_EN
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
            fill_nib   <= 4'd0;
            fill_bank  <= 6'd0;
            fill_half  <= 1'b0;
            fill_ptr   <= 10'd0;
`endif
        end else begin
            host_ack <= 1'b0;
`ifdef COLOR_FILL_EN
            fill_done <= 1'b0;

            // The fill target is frozen here, so later bank register
            // writes cannot redirect a fill already under way.
            if (fill_start && !fill_busy) begin
                fill_busy <= 1'b1;
                fill_nib  <= fill_value;
                fill_bank <= bank_reg[5:0];
                fill_half <= bank_reg[6];
                fill_ptr  <= 10'd0;
            end
`endif

            case (state)
                IDLE: begin
                    if (host_req) begin
                        // Host wins over fill; the strobe half is the one
                        // in effect now, even for a bank register write.
                        state     <= SETUP;
                        acc_host  <= 1'b1;
                        acc_we    <= host_we;
                        acc_half  <= bank_reg[6];
                        acc_addr  <= host_addr;
                        acc_wdata <= host_wdata;
                        mem_addr  <= {bank_reg[5:0], host_addr};
                        mem_wdata <= host_wdata;
                        _ce_mem   <= 1'b0;
                        _lb       <= bank_reg[6];
                        _ub       <= ~bank_reg[6];
                    end
`ifdef COLOR_FILL_EN
                    else if (fill_busy) begin
                        // One fill write per grant keeps host wait short.
                        state     <= SETUP;
                        acc_host  <= 1'b0;
                        acc_we    <= 1'b1;
                        acc_half  <= fill_half;
                        acc_addr  <= fill_ptr;
                        acc_wdata <= fill_nib;
                        mem_addr  <= {fill_bank, fill_ptr};
                        mem_wdata <= fill_nib;
                        _ce_mem   <= 1'b0;
                        _lb       <= fill_half;
                        _ub       <= ~fill_half;
                    end
`endif
                end

                SETUP: begin
                    state <= STROBE;
                    if (acc_we) begin
                        _we_mem   <= 1'b0;
                        mem_drive <= 1'b1;
                    end
                end

                STROBE: begin
                    state     <= FINISH;
                    _we_mem   <= 1'b1;
                    mem_drive <= 1'b0;
                    if (acc_host) begin
                        host_ack <= 1'b1;
                        if (!acc_we) begin
                            host_rdata <= acc_half ? mem_rdata[7:4]
                                                   : mem_rdata[3:0];
                        end else if (acc_addr == BANK_LO_ADDR) begin
                            bank_reg[3:0] <= acc_wdata;
                        end else if (acc_addr == BANK_HI_ADDR) begin
                            bank_reg[6:4] <= acc_wdata[2:0];
                        end
                    end
`ifdef COLOR_FILL_EN
                    else begin
                        fill_ptr <= fill_ptr + 10'd1;
                        if (fill_ptr == LAST_PTR) begin
                            fill_busy <= 1'b0;
                            fill_done <= 1'b1;
                        end
                    end
`endif
                end

                FINISH: begin
                    state   <= IDLE;
                    _ce_mem <= 1'b1;
                    _lb     <= 1'b1;
                    _ub     <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_mem_arbiter.sv
// tb_color_mem_arbiter: table vectors, hand sequences and random host traffic
// against a nibble-level memory/bank model; the SRAM is modelled as a byte array.

module tb_color_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        host_req;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [3:0]  host_wdata;
    logic [3:0]  host_rdata;
    logic        host_ack;
    logic        fill_start;
    logic [3:0]  fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic [5:0]  bank;
    logic [15:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_drive;
    logic        _ce_mem;
    logic        _we_mem;
    logic        _lb;
    logic        _ub;

    color_mem_arbiter dut (
        .clock(clock),
        .reset(reset),
        .host_req(host_req),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .host_ack(host_ack),
        .fill_start(fill_start),
        .fill_value(fill_value),
        .fill_busy(fill_busy),
        .fill_done(fill_done),
        .bank(bank),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_drive(mem_drive),
        ._ce_mem(_ce_mem),
        ._we_mem(_we_mem),
        ._lb(_lb),
        ._ub(_ub)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- SRAM model and bus monitor ----------------
    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  d;
        logic        up;
    } wr_t;

    logic [7:0] sram [65536];
    wr_t        wq[$];
    int         done_cnt = 0;
    int         ack_cnt  = 0;
    int         ce_cnt   = 0;
    int         busy_cnt = 0;

    assign mem_rdata = sram[mem_addr];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act,
                               input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clock) begin
        if (fill_done) done_cnt++;
        if (host_ack) ack_cnt++;
        if (fill_busy) busy_cnt++;
        if (_ce_mem) begin
            check("idle_pins", 32'({_we_mem, _lb, _ub, mem_drive}), 32'hE);
        end else begin
            ce_cnt++;
            check("active_pins", 32'({_lb ^ _ub, _we_mem ^ mem_drive}), 32'h3);
            if (!_we_mem) begin
                wr_t w;
                if (!_lb) sram[mem_addr][3:0] = mem_wdata;
                if (!_ub) sram[mem_addr][7:4] = mem_wdata;
                w.a  = mem_addr;
                w.d  = mem_wdata;
                w.up = ~_ub;
                wq.push_back(w);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [3:0] ref_lo [65536];
    logic [3:0] ref_hi [65536];
    logic [6:0] bank_ref = 7'd0;
    logic [3:0] last_rd  = 4'd0;

    task automatic ref_access(input logic we, input logic [9:0] a,
                              input logic [3:0] wd, output logic [15:0] ea,
                              output logic eu, output logic [3:0] er);
        ea = {bank_ref[5:0], a};
        eu = bank_ref[6];
        if (we) begin
            if (eu) ref_hi[ea] = wd;
            else    ref_lo[ea] = wd;
            if (a == 10'h3FE)      bank_ref[3:0] = wd;
            else if (a == 10'h3FF) bank_ref[6:4] = wd[2:0];
        end else begin
            last_rd = eu ? ref_hi[ea] : ref_lo[ea];
        end
        er = last_rd;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one host access; reports the bus view over SETUP/STROBE/FINISH.
    task automatic host_op(input logic we, input logic [9:0] a,
                           input logic [3:0] wd, input logic pulse,
                           output logic [3:0] rd, output int lat,
                           output logic [15:0] addr, output logic upper,
                           output logic shape_ok);
        logic [15:0] ha [3];
        logic        hce [3];
        logic        hwe [3];
        logic        got;
        for (int i = 0; i < 3; i++) begin
            ha[i] = 16'd0; hce[i] = 1'b1; hwe[i] = 1'b1;
        end
        host_we = we; host_addr = a; host_wdata = wd; host_req = 1'b1;
        if (pulse) fill_start = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            fill_start = 1'b0;
            ha[0] = ha[1]; ha[1] = ha[2]; ha[2] = mem_addr;
            hce[0] = hce[1]; hce[1] = hce[2]; hce[2] = _ce_mem;
            hwe[0] = hwe[1]; hwe[1] = hwe[2]; hwe[2] = _we_mem;
            if (host_ack) got = 1'b1;
        end
        host_req = 1'b0;
        rd    = host_rdata;
        addr  = ha[2];
        upper = ~_ub;
        shape_ok = got && ha[0] == ha[1] && ha[1] == ha[2]
                   && {hce[0], hce[1], hce[2]} == 3'b000
                   && {hwe[0], hwe[1], hwe[2]} == (we ? 3'b101 : 3'b111);
        tick();
    endtask

    task automatic do_host(input logic we, input logic [9:0] a,
                           input logic [3:0] wd, input logic pulse,
                           input int max_lat, input string tag);
        logic [15:0] ea, sa;
        logic        eu, su, ok;
        logic [3:0]  er, rd;
        int          lat;
        ref_access(we, a, wd, ea, eu, er);
        host_op(we, a, wd, pulse, rd, lat, sa, su, ok);
        check_range({tag, "_lat"}, lat, 3, max_lat);
        check({tag, "_addr"}, 32'(sa), 32'(ea));
        check({tag, "_half"}, 32'(su), 32'(eu));
        check({tag, "_shape"}, 32'(ok), 32'd1);
        check({tag, "_rdata"}, 32'(rd), 32'(er));
        check({tag, "_bank"}, 32'(bank), 32'(bank_ref[5:0]));
    endtask

    task automatic wait_we_low(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (!_we_mem) found = 1'b1;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  wdata;
        logic [15:0] exp_addr;
        logic        exp_upper;
        logic [5:0]  exp_bank;
        logic [3:0]  exp_rdata;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(logic we, logic [9:0] a, logic [3:0] wd,
                                logic [15:0] ea, logic eu, logic [5:0] eb,
                                logic [3:0] er);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.exp_addr = ea;
        v.exp_upper = eu; v.exp_bank = eb; v.exp_rdata = er;
        return v;
    endfunction

    initial begin
        logic [15:0] ea, sa;
        logic        eu, su, ok, found;
        logic [3:0]  er, rd;
        int          lat, d0, c0, a0;

        vecs[0]  = mk(1'b1, 10'h3FE, 4'h5, 16'h03FE, 1'b0, 6'h05, 4'h0);
        vecs[1]  = mk(1'b1, 10'h3FF, 4'h4, 16'h17FF, 1'b0, 6'h05, 4'h0);
        vecs[2]  = mk(1'b1, 10'h010, 4'hA, 16'h1410, 1'b1, 6'h05, 4'h0);
        vecs[3]  = mk(1'b0, 10'h010, 4'h0, 16'h1410, 1'b1, 6'h05, 4'hA);
        vecs[4]  = mk(1'b1, 10'h3FF, 4'h0, 16'h17FF, 1'b1, 6'h05, 4'hA);
        vecs[5]  = mk(1'b0, 10'h010, 4'h0, 16'h1410, 1'b0, 6'h05, 4'h3);
        vecs[6]  = mk(1'b1, 10'h3FE, 4'hF, 16'h17FE, 1'b0, 6'h0F, 4'h3);
        vecs[7]  = mk(1'b1, 10'h3FF, 4'h7, 16'h3FFF, 1'b0, 6'h3F, 4'h3);
        vecs[8]  = mk(1'b1, 10'h000, 4'h9, 16'hFC00, 1'b1, 6'h3F, 4'h3);
        vecs[9]  = mk(1'b0, 10'h000, 4'h0, 16'hFC00, 1'b1, 6'h3F, 4'h9);
        vecs[10] = mk(1'b1, 10'h3FF, 4'h3, 16'hFFFF, 1'b1, 6'h3F, 4'h9);
        vecs[11] = mk(1'b0, 10'h3FE, 4'h0, 16'hFFFE, 1'b0, 6'h3F, 4'h0);

        for (int i = 0; i < 65536; i++) begin
            sram[i] = 8'h00; ref_lo[i] = 4'h0; ref_hi[i] = 4'h0;
        end
        // Lower half of 0x1410 holds 3 so the later read sees byte 0xA3.
        sram[16'h1410]   = 8'h03;
        ref_lo[16'h1410] = 4'h3;

        reset = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = 10'd0;
        host_wdata = 4'd0; fill_start = 1'b0; fill_value = 4'd0;
        tick(); tick();
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_pins", 32'({_ce_mem, _we_mem, _lb, _ub, mem_drive}), 32'h1E);
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_fill", 32'({fill_busy, fill_done}), 32'd0);
        reset = 1'b0;
        tick();

        // Directed vectors; host ack lands in the 4th cycle counting the
        // request cycle, i.e. 3 edges after the request is first sampled.
        for (int i = 0; i < 12; i++) begin
            ref_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, ea, eu, er);
            host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0,
                    rd, lat, sa, su, ok);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_addr", i), 32'(sa), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_half", i), 32'(su), 32'(vecs[i].exp_upper));
            check($sformatf("vec%0d_shape", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_bank", i), 32'(bank), 32'(vecs[i].exp_bank));
        end

        // host_req dropped after the grant: the write still completes.
        ref_access(1'b1, 10'h005, 4'hC, ea, eu, er);
        host_we = 1'b1; host_addr = 10'h005; host_wdata = 4'hC;
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
        tick(); tick();
        check("drop_ack", 32'(host_ack), 32'd1);
        tick(); tick();
        check("drop_idle", 32'(_ce_mem), 32'd1);
        do_host(1'b0, 10'h005, 4'h0, 1'b0, 3, "drop_rd");

        // Random host traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic [9:0] a;
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 10'h3FE;
            else if (r == 1) a = 10'h3FF;
            else             a = 10'($urandom_range(0, 7));
            do_host(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                    1'b0, 3, "rnd");
        end

`ifdef COLOR_FILL_EN
        // Fill bank 0x02 lower with 7; host read in the same start cycle.
        do_host(1'b1, 10'h3FE, 4'h2, 1'b0, 3, "fsetlo");
        do_host(1'b1, 10'h3FF, 4'h0, 1'b0, 3, "fsethi");
        wq.delete();
        d0 = done_cnt;
        fill_value = 4'h7;
        do_host(1'b0, 10'h010, 4'h0, 1'b1, 3, "fill_first");
        check("fill_busy_set", 32'(fill_busy), 32'd1);

        // Host during a fill strobe, retargeting bank and retriggering fill.
        wait_we_low(20, found);
        check("fill_strobe_seen", 32'(found), 32'd1);
        fill_value = 4'hE;
        do_host(1'b1, 10'h3FE, 4'h3, 1'b1, 7, "fill_host");

        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            tick();
            if (fill_done) found = 1'b1;
        end
        check("fill_done_seen", 32'(found), 32'd1);
        check("fill_busy_clr", 32'(fill_busy), 32'd0);
        repeat (10) tick();
        check("fill_done_once", 32'(done_cnt - d0), 32'd1);
        begin
            int k, nonfill;
            logic seq_ok;
            k = 0; nonfill = 0; seq_ok = 1'b1;
            foreach (wq[i]) begin
                if (wq[i].d != 4'h7) begin
                    nonfill++;
                end else begin
                    if (wq[i].a != 16'h0800 + 16'(k) || wq[i].up) seq_ok = 1'b0;
                    k++;
                end
            end
            check("fill_count", 32'(k), 32'd1024);
            check("fill_seq", 32'(seq_ok), 32'd1);
            check("fill_nonfill", 32'(nonfill), 32'd1);
        end
        for (int i = 16'h0800; i <= 16'h0BFF; i++) ref_lo[i] = 4'h7;
        do_host(1'b1, 10'h3FE, 4'h2, 1'b0, 3, "fill_back");
        do_host(1'b0, 10'h123, 4'h0, 1'b0, 3, "fill_rd1");
        do_host(1'b0, 10'h3FE, 4'h0, 1'b0, 3, "fill_rd2");

        // Reset during a fill write cancels it without fill_done.
        fill_value = 4'h1;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        wait_we_low(20, found);
        check("frst_strobe_seen", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        check("frst_busy", 32'(fill_busy), 32'd0);
        check("frst_pins", 32'({_ce_mem, _we_mem}), 32'h3);
        reset = 1'b0;
        d0 = done_cnt; c0 = ce_cnt;
        repeat (20) tick();
        check("frst_no_done", 32'(done_cnt - d0), 32'd0);
        check("frst_no_access", 32'(ce_cnt - c0), 32'd0);
        bank_ref = 7'd0; last_rd = 4'd0;
`else
        // Without the fill engine a fill_start must cause nothing.
        c0 = ce_cnt; d0 = done_cnt; a0 = busy_cnt;
        fill_value = 4'h5;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (30) tick();
        check("nofill_access", 32'(ce_cnt - c0), 32'd0);
        check("nofill_done", 32'(done_cnt - d0), 32'd0);
        check("nofill_busy", 32'(busy_cnt - a0), 32'd0);
        do_host(1'b0, 10'h005, 4'h0, 1'b0, 3, "nofill_rd");
`endif

        // Reset in the STROBE cycle of a host write.
        host_we = 1'b1; host_addr = 10'h006; host_wdata = 4'h1;
        host_req = 1'b1;
        tick(); tick();
        check("hrst_pre_we", 32'(_we_mem), 32'd0);
        reset = 1'b1;
        host_req = 1'b0;
        tick();
        check("hrst_pins", 32'({_ce_mem, _we_mem, _lb, _ub, mem_drive}), 32'h1E);
        check("hrst_ack", 32'(host_ack), 32'd0);
        check("hrst_busy", 32'(fill_busy), 32'd0);
        check("hrst_bank", 32'(bank), 32'd0);
        check("hrst_rdata", 32'(host_rdata), 32'd0);
        reset = 1'b0;
        a0 = ack_cnt;
        repeat (6) tick();
        check("hrst_no_ack", 32'(ack_cnt - a0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
